// File: rtl/uart_tx_arbiter_if.sv
// Requester and transceiver-side signals of the UART transmit arbiter.
// The master side is the arbiter; the slave side is the requesters plus transceiver.
interface uart_tx_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_done;

  modport master (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_data, tx_wr
  );

  modport slave (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_data, tx_wr
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path among four byte requesters,
// one byte per grant, with a tx_done watchdog and a sticky timeout flag.
module uart_tx_arbiter #(
  parameter int TIMEOUT   = 200000,
  parameter int TIMEOUT_W = 20
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                enable,
  input  logic                err_clr,
  output logic                busy,
  output logic [1:0]          grant,
  output logic                timeout_err,
  uart_tx_arbiter_if.master   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t               state, state_n;
  logic [1:0]           last, last_n;
  logic [TIMEOUT_W-1:0] wd, wd_n;
  logic                 tx_wr_n, busy_n, err_n;
  logic [3:0]           rdy_n;
  logic [7:0]           data_n;
  logic [1:0]           grant_n;
  logic [1:0]           idx, pick;
  logic                 pick_ok;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      last          <= 2'd3;
      wd            <= '0;
      bus.tx_wr     <= 1'b0;
      bus.tx_data   <= '0;
      bus.req_ready <= '0;
      busy          <= 1'b0;
      grant         <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_n;
      last          <= last_n;
      wd            <= wd_n;
      bus.tx_wr     <= tx_wr_n;
      bus.tx_data   <= data_n;
      bus.req_ready <= rdy_n;
      busy          <= busy_n;
      grant         <= grant_n;
      timeout_err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    wd_n    = wd;
    tx_wr_n = 1'b0;
    rdy_n   = '0;
    data_n  = bus.tx_data;
    grant_n = grant;
    busy_n  = busy;
    err_n   = err_clr ? 1'b0 : timeout_err;
    pick_ok = 1'b0;
    pick    = '0;
    idx     = '0;

    // Search starts just past the last winner so every requester gets a turn.
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!pick_ok && bus.req_valid[idx]) begin
        pick_ok = 1'b1;
        pick    = idx;
      end
    end

    case (state)
      IDLE: begin
        if (enable && pick_ok) begin
          state_n = ISSUE;
          data_n  = bus.req_data[{pick, 3'b000} +: 8];
          grant_n = pick;
          busy_n  = 1'b1;
        end else begin
          busy_n  = 1'b0;
        end
      end
      ISSUE: begin
        tx_wr_n      = 1'b1;
        rdy_n[grant] = 1'b1;
        last_n       = grant;
        wd_n         = '0;
        state_n      = WAIT;
      end
      WAIT: begin
        wd_n = wd + 1'b1;
        // tx_done takes precedence over a coincident watchdog expiry.
        if (bus.tx_done) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else if (TIMEOUT != 0 && wd == WD_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued at stimulus
// time and compared on every tx_wr strobe.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] d;
    logic [3:0] r;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       err_clr = 1'b0;
  logic       busy;
  logic [1:0] grant;
  logic       timeout_err;
  logic       auto_done = 1'b0;
  logic       man_done = 1'b0;
  int         done_dly = 0;
  int         dcnt = 0;
  int         nwr = 0;
  int         total = 0;
  int         bad = 0;
  int         snap;
  exp_t       sb[$];

  uart_tx_arbiter_if u_if ();

  uart_tx_arbiter #(.TIMEOUT(16), .TIMEOUT_W(8)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .enable      (enable),
    .err_clr     (err_clr),
    .busy        (busy),
    .grant       (grant),
    .timeout_err (timeout_err),
    .bus         (u_if)
  );

  assign u_if.tx_done = auto_done | man_done;

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic [7:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    e.r = 4'b0001 << g;
    sb.push_back(e);
  endtask

  // Transceiver model: answers each tx_wr with tx_done after done_dly cycles.
  always @(negedge sys_clk) begin
    auto_done = 1'b0;
    if (!sys_rst_n) dcnt = 0;
    else begin
      if (dcnt > 0) begin
        dcnt = dcnt - 1;
        if (dcnt == 0) auto_done = 1'b1;
      end
      if (u_if.tx_wr && done_dly > 0) dcnt = done_dly;
    end
  end

  // Scoreboard monitor.
  always @(negedge sys_clk) begin
    if (u_if.tx_wr) begin
      nwr++;
      if (sb.size() == 0) chk("unexpected_wr", 32'(u_if.tx_data), 32'hFFFF);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("tx_data", 32'(u_if.tx_data), 32'(e.d));
        chk("req_ready", 32'(u_if.req_ready), 32'(e.r));
        chk("grant", 32'(grant), 32'(e.g));
      end
    end else if (u_if.req_ready != 4'b0) begin
      chk("stray_ready", 32'(u_if.req_ready), 32'h0);
    end
  end

  task automatic wait_wr(input bit drop);
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!u_if.tx_wr && n < 200);
    if (!u_if.tx_wr) chk("wr_wait_expired", 32'h0, 32'h1);
    else if (drop) u_if.req_valid = u_if.req_valid & ~u_if.req_ready;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    chk("idle_wait", 32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    u_if.req_valid = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    u_if.req_valid = '0;
    u_if.req_data  = '0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("rst_tx_wr", 32'(u_if.tx_wr), 32'h0);
    chk("rst_tx_data", 32'(u_if.tx_data), 32'h0);
    chk("rst_ready", 32'(u_if.req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_err", 32'(timeout_err), 32'h0);

    // Single byte with latency check.
    enable = 1'b1;
    done_dly = 5;
    u_if.req_data = 32'h0000_0041;
    u_if.req_valid = 4'b0001;
    push(2'd0, 8'h41);
    @(negedge sys_clk);
    chk("lat_edge1_wr", 32'(u_if.tx_wr), 32'h0);
    chk("lat_edge1_busy", 32'(busy), 32'h1);
    @(negedge sys_clk);
    chk("lat_edge2_wr", 32'(u_if.tx_wr), 32'h1);
    u_if.req_valid = '0;
    wait_idle();

    // All four continuously requesting.
    do_reset();
    u_if.req_data = 32'h4030_2010;
    u_if.req_valid = 4'b1111;
    push(2'd0, 8'h10); push(2'd1, 8'h20); push(2'd2, 8'h30); push(2'd3, 8'h40); push(2'd0, 8'h10);
    for (int i = 0; i < 5; i++) wait_wr(1'b0);
    u_if.req_valid = '0;
    wait_idle();
    chk("rr_sb_empty", 32'(sb.size()), 32'h0);

    // Requesters 1 and 3 only, after a grant to 1.
    do_reset();
    u_if.req_data = 32'h7300_5100;
    u_if.req_valid = 4'b0010;
    push(2'd1, 8'h51);
    wait_wr(1'b1);
    wait_idle();
    u_if.req_data = 32'h7300_5200;
    u_if.req_valid = 4'b1010;
    push(2'd3, 8'h73); push(2'd1, 8'h52);
    wait_wr(1'b1);
    wait_wr(1'b1);
    wait_idle();

    // Watchdog timeout, set-over-clear, re-grant, clear, and tx_done winning a tie.
    do_reset();
    done_dly = 0;
    u_if.req_data = 32'h0000_A1A0;
    u_if.req_valid = 4'b0011;
    push(2'd0, 8'hA0); push(2'd1, 8'hA1);
    wait_wr(1'b1);
    repeat (14) @(negedge sys_clk);
    err_clr = 1'b1;
    @(negedge sys_clk);
    chk("to_err_early", 32'(timeout_err), 32'h0);
    @(negedge sys_clk);
    err_clr = 1'b0;
    chk("to_err_set_wins", 32'(timeout_err), 32'h1);
    chk("to_busy", 32'(busy), 32'h0);
    wait_wr(1'b1);
    chk("to_err_sticky", 32'(timeout_err), 32'h1);
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    chk("to_err_clr", 32'(timeout_err), 32'h0);
    repeat (14) @(negedge sys_clk);
    man_done = 1'b1;
    @(negedge sys_clk);
    man_done = 1'b0;
    chk("tie_no_err", 32'(timeout_err), 32'h0);
    chk("tie_busy", 32'(busy), 32'h0);

    // enable gating.
    do_reset();
    done_dly = 5;
    enable = 1'b0;
    u_if.req_data = 32'h00C2_00C0;
    u_if.req_valid = 4'b0100;
    snap = nwr;
    repeat (10) @(negedge sys_clk);
    chk("en0_no_wr", 32'(nwr - snap), 32'h0);
    chk("en0_busy", 32'(busy), 32'h0);
    push(2'd2, 8'hC2);
    enable = 1'b1;
    wait_wr(1'b1);
    enable = 1'b0;
    u_if.req_valid = 4'b0001;
    wait_idle();
    snap = nwr;
    repeat (10) @(negedge sys_clk);
    chk("en_drop_no_wr", 32'(nwr - snap), 32'h0);
    push(2'd0, 8'hC0);
    enable = 1'b1;
    wait_wr(1'b1);
    wait_idle();

    // Reset in WAIT, then a late tx_done.
    done_dly = 0;
    u_if.req_data = 32'hD300_0000;
    u_if.req_valid = 4'b1000;
    push(2'd3, 8'hD3);
    wait_wr(1'b1);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk("wrst_tx_wr", 32'(u_if.tx_wr), 32'h0);
    chk("wrst_tx_data", 32'(u_if.tx_data), 32'h0);
    chk("wrst_ready", 32'(u_if.req_ready), 32'h0);
    chk("wrst_busy", 32'(busy), 32'h0);
    chk("wrst_grant", 32'(grant), 32'h0);
    chk("wrst_err", 32'(timeout_err), 32'h0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    man_done = 1'b1;
    @(negedge sys_clk);
    man_done = 1'b0;
    snap = nwr;
    repeat (10) @(negedge sys_clk);
    chk("late_done_no_wr", 32'(nwr - snap), 32'h0);
    chk("late_done_busy", 32'(busy), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
